mlp_sequencer: RTL and testbench

Command-driven controller that sequences one MLP inference on the 2x2 MLP top.
- Accepts a command of 4 weight bytes plus a 16-bit activation word.
- Drives the weight FIFO reset and column pushes, the activation load, weights_ready and start_mlp.
- Waits for the MLP done state, then captures acc0/acc1 into a result register with a valid/ready output handshake.
- Sits between the host/UART command layer and the MLP-facing bridge inputs (ctrl_* signals); replaces hand-sequenced control.

---
 rtl/mlp_sequencer_if.sv | 23 ++
 rtl/mlp_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_mlp_sequencer.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/mlp_sequencer_if.sv
// Host-side command and result handshake for the MLP sequencer.
// The master drives commands and consumes results; the slave is the sequencer.
interface mlp_sequencer_if;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [31:0]        cmd_weights;
  logic [15:0]        cmd_act;
  logic               res_valid;
  logic               res_ready;
  logic signed [31:0] res_acc0;
  logic signed [31:0] res_acc1;
  logic               res_timeout;

  modport master (
    output cmd_valid, cmd_weights, cmd_act, res_ready,
    input  cmd_ready, res_valid, res_acc0, res_acc1, res_timeout
  );

  modport slave (
    input  cmd_valid, cmd_weights, cmd_act, res_ready,
    output cmd_ready, res_valid, res_acc0, res_acc1, res_timeout
  );
endinterface

// File: rtl/mlp_sequencer.sv
// Sequences one 2x2 MLP inference: weight FIFO load, activation load, start,
// wait for done (or time out), then presents the accumulators to the host.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a command; cmd_ready high
// WF_RST  | weight FIFO reset pulse
// PUSH0   | two pushes of column 0 weights (w0, w1)
// PUSH1   | two pushes of column 1 weights (w0, w1)
// ACT     | activation load strobe
// LOAD    | weights_ready pulse
// START   | start_mlp pulse
// WAIT    | counting cycles until the MLP reports done or the timeout expires
// RESP    | result held on res_* until the host accepts it
module mlp_sequencer #(
  parameter logic [3:0] DONE_STATE     = 4'd5,
  parameter int         TIMEOUT_CYCLES = 256,
  parameter int         CNT_W          = 9
) (
  input  logic               clk,
  input  logic               rst,
  mlp_sequencer_if.slave     host,
  output logic               ctrl_wf_reset,
  output logic               ctrl_wf_push_col0,
  output logic               ctrl_wf_push_col1,
  output logic [7:0]         ctrl_wf_data_in,
  output logic               ctrl_init_act_valid,
  output logic [15:0]        ctrl_init_act_data,
  output logic               ctrl_weights_ready,
  output logic               ctrl_start_mlp,
  input  logic [3:0]         mlp_state_in,
  input  logic signed [31:0] mlp_acc0_in,
  input  logic signed [31:0] mlp_acc1_in,
  output logic               busy
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_WF_RST,
    S_PUSH0,
    S_PUSH1,
    S_ACT,
    S_LOAD,
    S_START,
    S_WAIT,
    S_RESP
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t             state;
  logic [31:0]        lat_weights;
  logic [15:0]        lat_act;
  logic               push_second;
  logic [CNT_W-1:0]   wait_cnt;
  logic               res_valid_q;
  logic signed [31:0] res_acc0_q;
  logic signed [31:0] res_acc1_q;
  logic               res_timeout_q;

  assign host.cmd_ready   = (state == S_IDLE);
  assign host.res_valid   = res_valid_q;
  assign host.res_acc0    = res_acc0_q;
  assign host.res_acc1    = res_acc1_q;
  assign host.res_timeout = res_timeout_q;

  // Outputs are assigned alongside the transition into the state that owns
  // them, so each pulse is high exactly while that state is current.
  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= S_IDLE;
      lat_weights         <= '0;
      lat_act             <= '0;
      push_second         <= 1'b0;
      wait_cnt            <= '0;
      ctrl_wf_reset       <= 1'b0;
      ctrl_wf_push_col0   <= 1'b0;
      ctrl_wf_push_col1   <= 1'b0;
      ctrl_wf_data_in     <= '0;
      ctrl_init_act_valid <= 1'b0;
      ctrl_init_act_data  <= '0;
      ctrl_weights_ready  <= 1'b0;
      ctrl_start_mlp      <= 1'b0;
      busy                <= 1'b0;
      res_valid_q         <= 1'b0;
      res_acc0_q          <= '0;
      res_acc1_q          <= '0;
      res_timeout_q       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (host.cmd_valid) begin
            lat_weights   <= host.cmd_weights;
            lat_act       <= host.cmd_act;
            ctrl_wf_reset <= 1'b1;
            busy          <= 1'b1;
            state         <= S_WF_RST;
          end
        end

        S_WF_RST: begin
          ctrl_wf_reset     <= 1'b0;
          ctrl_wf_push_col0 <= 1'b1;
          ctrl_wf_data_in   <= lat_weights[7:0];
          push_second       <= 1'b0;
          state             <= S_PUSH0;
        end

        S_PUSH0: begin
          if (!push_second) begin
            ctrl_wf_data_in <= lat_weights[15:8];
            push_second     <= 1'b1;
          end else begin
            ctrl_wf_push_col0 <= 1'b0;
            ctrl_wf_push_col1 <= 1'b1;
            ctrl_wf_data_in   <= lat_weights[23:16];
            push_second       <= 1'b0;
            state             <= S_PUSH1;
          end
        end

        S_PUSH1: begin
          if (!push_second) begin
            ctrl_wf_data_in <= lat_weights[31:24];
            push_second     <= 1'b1;
          end else begin
            ctrl_wf_push_col1   <= 1'b0;
            ctrl_wf_data_in     <= '0;
            push_second         <= 1'b0;
            ctrl_init_act_valid <= 1'b1;
            ctrl_init_act_data  <= lat_act;
            state               <= S_ACT;
          end
        end

        S_ACT: begin
          ctrl_init_act_valid <= 1'b0;
          ctrl_weights_ready  <= 1'b1;
          state               <= S_LOAD;
        end

        S_LOAD: begin
          ctrl_weights_ready <= 1'b0;
          ctrl_start_mlp     <= 1'b1;
          state              <= S_START;
        end

        S_START: begin
          ctrl_start_mlp <= 1'b0;
          wait_cnt       <= '0;
          state          <= S_WAIT;
        end

        // Done is checked first so a done on the last timeout cycle still
        // returns real accumulator values.
        S_WAIT: begin
          if (mlp_state_in == DONE_STATE) begin
            res_acc0_q    <= mlp_acc0_in;
            res_acc1_q    <= mlp_acc1_in;
            res_timeout_q <= 1'b0;
            res_valid_q   <= 1'b1;
            state         <= S_RESP;
          end else if (wait_cnt == CNT_LAST) begin
            res_acc0_q    <= '0;
            res_acc1_q    <= '0;
            res_timeout_q <= 1'b1;
            res_valid_q   <= 1'b1;
            state         <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end

        S_RESP: begin
          if (host.res_ready) begin
            res_valid_q <= 1'b0;
            busy        <= 1'b0;
            state       <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mlp_sequencer.sv
// Directed and randomized commands against a cycle-numbered reference model
// of the sequencer's command-to-result timeline.
module tb_mlp_sequencer;
  localparam logic [3:0] DONE_STATE     = 4'd5;
  localparam int         TIMEOUT_CYCLES = 256;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               ctrl_wf_reset;
  logic               ctrl_wf_push_col0;
  logic               ctrl_wf_push_col1;
  logic [7:0]         ctrl_wf_data_in;
  logic               ctrl_init_act_valid;
  logic [15:0]        ctrl_init_act_data;
  logic               ctrl_weights_ready;
  logic               ctrl_start_mlp;
  logic [3:0]         mlp_state_in = 4'd0;
  logic signed [31:0] mlp_acc0_in = '0;
  logic signed [31:0] mlp_acc1_in = '0;
  logic               busy;

  int checks = 0;
  int errors = 0;
  logic [15:0] prev_act = 16'h0;
  logic signed [31:0] last_acc0 = '0;
  logic signed [31:0] last_acc1 = '0;

  mlp_sequencer_if bus ();

  mlp_sequencer #(
    .DONE_STATE(DONE_STATE),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W(9)
  ) dut (
    .clk(clk),
    .rst(rst),
    .host(bus),
    .ctrl_wf_reset(ctrl_wf_reset),
    .ctrl_wf_push_col0(ctrl_wf_push_col0),
    .ctrl_wf_push_col1(ctrl_wf_push_col1),
    .ctrl_wf_data_in(ctrl_wf_data_in),
    .ctrl_init_act_valid(ctrl_init_act_valid),
    .ctrl_init_act_data(ctrl_init_act_data),
    .ctrl_weights_ready(ctrl_weights_ready),
    .ctrl_start_mlp(ctrl_start_mlp),
    .mlp_state_in(mlp_state_in),
    .mlp_acc0_in(mlp_acc0_in),
    .mlp_acc1_in(mlp_acc1_in),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [16:0] ctrl_vec();
    return {ctrl_wf_reset, ctrl_wf_push_col0, ctrl_wf_push_col1, ctrl_wf_data_in,
            ctrl_init_act_valid, ctrl_weights_ready, ctrl_start_mlp, busy,
            bus.cmd_ready, bus.res_valid};
  endfunction

  // Expected control picture for cycle k counted from the accepting edge.
  function automatic logic [16:0] model_ctrl(input int k, input logic [31:0] w);
    logic [7:0] b;
    b = (k >= 2 && k <= 5) ? w[(k-2)*8 +: 8] : 8'h00;
    return {(k == 1), (k == 2 || k == 3), (k == 4 || k == 5), b,
            (k == 6), (k == 7), (k == 8), 1'b1, 1'b0, 1'b0};
  endfunction

  function automatic logic [3:0] not_done_state();
    logic [3:0] v;
    v = 4'($urandom_range(0, 14));
    if (v >= DONE_STATE) v = v + 4'd1;
    return v;
  endfunction

  localparam logic [16:0] IDLE_VEC = 17'b0_0_0_00000000_0_0_0_0_1_0;
  localparam logic [16:0] RESP_VEC = 17'b0_0_0_00000000_0_0_0_1_0_1;

  // done_k <= 0 means the MLP never reports done; abort_k > 0 resets in that cycle.
  task automatic run_cmd(input logic [31:0] w, input logic [15:0] act, input int done_k,
                         input int a0, input int a1, input bit spurious,
                         input int hold, input int abort_k);
    int r;
    logic signed [31:0] exp0, exp1;
    chk("cmd_ready_before_cmd", {63'd0, bus.cmd_ready}, 64'd1);
    bus.cmd_valid   = 1'b1;
    bus.cmd_weights = w;
    bus.cmd_act     = act;
    r = (done_k > 0) ? done_k + 1 : 9 + TIMEOUT_CYCLES;
    tick();
    bus.cmd_valid   = 1'b0;
    bus.cmd_weights = $urandom;
    bus.cmd_act     = 16'($urandom);
    for (int k = 1; k < r; k++) begin
      if (k == done_k) begin
        mlp_state_in = DONE_STATE;
        mlp_acc0_in  = a0;
        mlp_acc1_in  = a1;
      end else begin
        mlp_state_in = (spurious && k <= 8) ? DONE_STATE : not_done_state();
        mlp_acc0_in  = $urandom;
        mlp_acc1_in  = $urandom;
      end
      chk($sformatf("ctrl_cycle%0d", k), {47'd0, ctrl_vec()}, {47'd0, model_ctrl(k, w)});
      chk($sformatf("act_data_cycle%0d", k), {48'd0, ctrl_init_act_data},
          {48'd0, (k >= 6) ? act : prev_act});
      if (k == abort_k) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mlp_state_in = not_done_state();
        chk("abort_ctrl", {47'd0, ctrl_vec()}, {47'd0, IDLE_VEC});
        chk("abort_act_data", {48'd0, ctrl_init_act_data}, 64'd0);
        chk("abort_res_acc0", {32'd0, bus.res_acc0}, 64'd0);
        chk("abort_res_timeout", {63'd0, bus.res_timeout}, 64'd0);
        prev_act  = 16'h0;
        last_acc0 = '0;
        last_acc1 = '0;
        return;
      end
      tick();
    end
    mlp_state_in = not_done_state();
    mlp_acc0_in  = $urandom;
    mlp_acc1_in  = $urandom;
    exp0 = (done_k > 0) ? a0 : 0;
    exp1 = (done_k > 0) ? a1 : 0;
    for (int h = 0; h <= hold; h++) begin
      chk($sformatf("resp_ctrl_h%0d", h), {47'd0, ctrl_vec()}, {47'd0, RESP_VEC});
      chk($sformatf("res_acc0_h%0d", h), {32'd0, bus.res_acc0}, {32'd0, exp0});
      chk($sformatf("res_acc1_h%0d", h), {32'd0, bus.res_acc1}, {32'd0, exp1});
      chk($sformatf("res_timeout_h%0d", h), {63'd0, bus.res_timeout},
          {63'd0, (done_k > 0) ? 1'b0 : 1'b1});
      if (h < hold) begin
        bus.res_ready   = 1'b0;
        bus.cmd_valid   = 1'b1;
        bus.cmd_weights = $urandom;
        tick();
      end
    end
    bus.cmd_valid = 1'b0;
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    chk("after_handshake_ctrl", {47'd0, ctrl_vec()}, {47'd0, IDLE_VEC});
    chk("persist_acc0", {32'd0, bus.res_acc0}, {32'd0, exp0});
    chk("persist_acc1", {32'd0, bus.res_acc1}, {32'd0, exp1});
    chk("persist_act_data", {48'd0, ctrl_init_act_data}, {48'd0, act});
    prev_act  = act;
    last_acc0 = exp0;
    last_acc1 = exp1;
  endtask

  initial begin
    bus.cmd_valid   = 1'b0;
    bus.cmd_weights = '0;
    bus.cmd_act     = '0;
    bus.res_ready   = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    chk("reset_ctrl", {47'd0, ctrl_vec()}, {47'd0, IDLE_VEC});
    chk("reset_act_data", {48'd0, ctrl_init_act_data}, 64'd0);
    chk("reset_res_acc0", {32'd0, bus.res_acc0}, 64'd0);
    chk("reset_res_acc1", {32'd0, bus.res_acc1}, 64'd0);
    chk("reset_res_timeout", {63'd0, bus.res_timeout}, 64'd0);

    // Basic: done 20 cycles after the start pulse (cycle 8).
    run_cmd(32'h04030201, 16'h0A05, 28, 100, -7, 1'b0, 0, 0);
    // Backpressure with a competing command held during the stall.
    run_cmd($urandom, 16'($urandom), 14, int'($urandom), int'($urandom), 1'b0, 10, 0);
    // Back-to-back with minimum spacing.
    run_cmd($urandom, 16'($urandom), 9, int'($urandom), int'($urandom), 1'b0, 0, 0);
    // Timeout: no done at all.
    run_cmd($urandom, 16'($urandom), 0, 0, 0, 1'b0, 2, 0);
    // Done on the final timeout cycle wins.
    run_cmd($urandom, 16'($urandom), 8 + TIMEOUT_CYCLES, int'($urandom), int'($urandom),
            1'b0, 0, 0);
    // Reset in the first PUSH1 cycle, then a clean run.
    run_cmd(32'hA1B2C3D4, 16'h5A5A, 20, 1, 2, 1'b0, 0, 4);
    run_cmd(32'h11223344, 16'h7E81, 12, -1, 32'sh7FFFFFFF, 1'b0, 1, 0);
    // Spurious done during the load sequence.
    run_cmd($urandom, 16'($urandom), 15, int'($urandom), int'($urandom), 1'b1, 0, 0);

    for (int i = 0; i < 6; i++) begin
      run_cmd($urandom, 16'($urandom), int'($urandom_range(9, 40)), int'($urandom),
              int'($urandom), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
